// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone generator.
// Holds the note list, half-period table builder, counter width and states.
package piano_pkg;

    localparam int CNT_W     = 17;
    localparam int NUM_NOTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_RELEASE
    } state_t;

    // Note frequencies in centi-Hz, C4 (index 0) up to C5 (index 7)
    localparam logic [NUM_NOTES-1:0][31:0] NOTE_CHZ = {
        32'd52325, 32'd49388, 32'd44000, 32'd39200,
        32'd34923, 32'd32963, 32'd29366, 32'd26163
    };

    typedef logic [NUM_NOTES-1:0][CNT_W-1:0] hp_tab_t;

    // round(clk_hz / (2 * f)) with f in centi-Hz, integer arithmetic only
    function automatic hp_tab_t hp_table(input longint unsigned clk_hz);
        hp_tab_t         t;
        longint unsigned f;
        for (int i = 0; i < NUM_NOTES; i++) begin
            f    = 64'(NOTE_CHZ[i]);
            t[i] = CNT_W'((clk_hz * 64'd100 + f) / (64'd2 * f));
        end
        return t;
    endfunction

endpackage

// File: rtl/piano_key_prio.sv
// Fixed-priority key encoder for the piano tone generator.
// The lowest-index pressed key wins.
module piano_key_prio
    import piano_pkg::*;
#(
    parameter int NUM_KEYS = 8
) (
    input  logic [NUM_KEYS-1:0] keys,
    output logic                valid,
    output logic [2:0]          index
);

    // Scan from the top down so the lowest pressed key is written last
    always_comb begin
        valid = 1'b0;
        index = 3'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                valid = 1'b1;
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/piano_tone_gen.sv
// Square-wave piano tone generator with IDLE/PLAY/RELEASE control.
// Define PIANO_SUSTAIN_EN to keep the last note ringing for SUSTAIN_CYC.
module piano_tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int          NUM_KEYS    = 8,
    parameter int unsigned SUSTAIN_CYC = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [1:0]          octave,
    output logic                speaker,
    output logic                active,
    output logic [2:0]          note_idx
);

    localparam hp_tab_t HP_TAB = hp_table(64'(CLK_HZ));

    logic [NUM_KEYS-1:0] keys_q;
    logic [1:0]          oct_q;
    logic                sel_valid;
    logic [2:0]          sel_idx;
    logic [CNT_W-1:0]    n_sel;
    logic [CNT_W-1:0]    n_cur;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      cnt_next;
    logic                at_edge;
    logic                sus_done;
    state_t              state;

    piano_key_prio #(
        .NUM_KEYS(NUM_KEYS)
    ) u_prio (
        .keys (keys_q),
        .valid(sel_valid),
        .index(sel_idx)
    );

    assign n_sel    = HP_TAB[sel_idx] >> oct_q;
    assign cnt_next = {1'b0, count} + (CNT_W+1)'(1);
    assign at_edge  = (cnt_next >= {1'b0, n_cur});

    // Register the raw inputs once before any use
    always_ff @(posedge clk) begin
        if (rst) begin
            keys_q <= '0;
            oct_q  <= '0;
        end else begin
            keys_q <= keys;
            oct_q  <= octave;
        end
    end

`ifdef PIANO_SUSTAIN_EN
    logic [31:0] sus_cnt;

    assign sus_done = (sus_cnt >= SUSTAIN_CYC);

    // Count cycles spent in RELEASE, holding once the tail has elapsed
    always_ff @(posedge clk) begin
        if (rst)
            sus_cnt <= '0;
        else if (state != ST_RELEASE)
            sus_cnt <= '0;
        else if (!sus_done)
            sus_cnt <= sus_cnt + 32'd1;
    end
`else
    assign sus_done = 1'b1 | (SUSTAIN_CYC == 0);
`endif

    // Tone FSM: note changes only land on half-period boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            n_cur    <= '0;
            speaker  <= 1'b0;
            active   <= 1'b0;
            note_idx <= 3'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        n_cur    <= n_sel;
                        note_idx <= sel_idx;
                        count    <= '0;
                        speaker  <= 1'b1;
                        active   <= 1'b1;
                        state    <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (at_edge) begin
                        count   <= '0;
                        speaker <= ~speaker;
                        if (sel_valid) begin
                            n_cur    <= n_sel;
                            note_idx <= sel_idx;
                        end
                    end else begin
                        count <= cnt_next[CNT_W-1:0];
                    end
                    if (!sel_valid)
                        state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (at_edge) begin
                        count <= '0;
                        if (sel_valid) begin
                            speaker  <= ~speaker;
                            n_cur    <= n_sel;
                            note_idx <= sel_idx;
                            state    <= ST_PLAY;
                        end else if (sus_done) begin
                            speaker  <= 1'b0;
                            active   <= 1'b0;
                            note_idx <= 3'd0;
                            state    <= ST_IDLE;
                        end else begin
                            speaker <= ~speaker;
                        end
                    end else begin
                        count <= cnt_next[CNT_W-1:0];
                        if (sel_valid)
                            state <= ST_PLAY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_tone_gen.sv
// Self-checking bench for piano_tone_gen.
// Directed timing checks plus a random run against a behavioural model.
module tb_piano_tone_gen;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned SUS    = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] keys = 8'd0;
    logic [1:0] octave = 2'd0;
    logic       speaker;
    logic       active;
    logic [2:0] note_idx;

    int tests = 0;
    int fails = 0;

    real freq [8] = '{261.63, 293.66, 329.63, 349.23,
                      392.00, 440.00, 493.88, 523.25};

    // model state: mode 0 idle, 1 play, 2 release
    int       m_mode = 0;
    int       m_remain = 0;
    int       m_len = 0;
    int       m_tail = 0;
    bit       m_spk = 1'b0;
    bit [2:0] m_note = 3'd0;
    bit [7:0] m_keys = 8'd0;
    int       m_oct = 0;

    always #5 clk = ~clk;

    piano_tone_gen #(
        .CLK_HZ     (CLK_HZ),
        .NUM_KEYS   (8),
        .SUSTAIN_CYC(SUS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys),
        .octave  (octave),
        .speaker (speaker),
        .active  (active),
        .note_idx(note_idx)
    );

    function automatic int hp(int i, int oct);
        int b;
        b = $rtoi(real'(CLK_HZ) / (2.0 * freq[i]) + 0.5);
        return b >> oct;
    endfunction

    function automatic int lowest(bit [7:0] k);
        for (int i = 0; i < 8; i++)
            if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        int sel;
        int old_mode;
        bit done;
        if (rst) begin
            m_mode = 0; m_spk = 0; m_note = 0;
            m_remain = 0; m_len = 0; m_tail = 0;
            m_keys = 0; m_oct = 0;
            return;
        end
        sel = lowest(m_keys);
`ifdef PIANO_SUSTAIN_EN
        done = (m_tail >= int'(SUS));
`else
        done = 1'b1;
`endif
        old_mode = m_mode;
        if (m_mode == 0) begin
            if (sel >= 0) begin
                m_mode = 1;
                m_spk = 1;
                m_note = 3'(sel);
                m_len = hp(sel, m_oct);
                m_remain = m_len;
            end
        end else begin
            m_remain--;
            if (m_remain == 0) begin
                if (sel >= 0) begin
                    m_spk = !m_spk;
                    m_note = 3'(sel);
                    m_len = hp(sel, m_oct);
                    m_mode = 1;
                end else if (m_mode == 2 && done) begin
                    m_mode = 0;
                    m_spk = 0;
                    m_note = 0;
                end else begin
                    m_spk = !m_spk;
                    m_mode = 2;
                end
                m_remain = m_len;
            end else begin
                m_mode = (sel >= 0) ? 1 : 2;
            end
        end
        m_tail = (old_mode == 2) ? m_tail + 1 : 0;
        m_keys = keys;
        m_oct = int'(octave);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_change(input int limit, output int n);
        logic s0;
        s0 = speaker;
        n = 0;
        while (speaker === s0 && n < limit) begin
            cyc();
            n++;
        end
        if (speaker === s0) n = -1;
    endtask

    task automatic test_reset();
        rst = 1; keys = 0; octave = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if ({speaker, active, note_idx} !== 5'd0) begin
                fails++;
                $display("FAIL reset_hold: got %b%b%0d want 000",
                         speaker, active, note_idx);
            end
        end
        keys = 8'hA5; octave = 2'd3;
        for (int i = 0; i < 2; i++) begin
            cyc();
            tests++;
            if ({speaker, active, note_idx} !== 5'd0) begin
                fails++;
                $display("FAIL reset_override: got %b%b%0d want 000",
                         speaker, active, note_idx);
            end
        end
        keys = 0; octave = 0; rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if ({speaker, active, note_idx} !== 5'd0) begin
                fails++;
                $display("FAIL idle_quiet: got %b%b%0d want 000",
                         speaker, active, note_idx);
            end
        end
    endtask

    task automatic test_single_note();
        int n;
        keys = 8'b0000_0100;
        wait_change(10, n);
        tests++;
        if (n !== 2) begin
            fails++;
            $display("FAIL e4_rise_delay: got %0d want 2", n);
        end
        tests++;
        if (note_idx !== 3'd2 || active !== 1'b1) begin
            fails++;
            $display("FAIL e4_note: got %0d/%b want 2/1", note_idx, active);
        end
        for (int i = 0; i < 2; i++) begin
            wait_change(hp(2, 0) + 10, n);
            tests++;
            if (n !== hp(2, 0)) begin
                fails++;
                $display("FAIL e4_half: got %0d want %0d", n, hp(2, 0));
            end
        end
    endtask

    task automatic test_priority();
        int n;
        rst = 1; keys = 0; cyc();
        rst = 0; keys = 8'b0010_0100;
        wait_change(10, n);
        tests++;
        if (n !== 2 || note_idx !== 3'd2) begin
            fails++;
            $display("FAIL prio_e4: got %0d/%0d want 2/2", n, note_idx);
        end
        repeat (300) cyc();
        keys = 8'b0010_0000;
        wait_change(hp(2, 0) + 10, n);
        tests++;
        if (n !== hp(2, 0) - 300) begin
            fails++;
            $display("FAIL switch_edge: got %0d want %0d", n, hp(2, 0) - 300);
        end
        tests++;
        if (note_idx !== 3'd5) begin
            fails++;
            $display("FAIL switch_note: got %0d want 5", note_idx);
        end
        wait_change(hp(5, 0) + 10, n);
        tests++;
        if (n !== hp(5, 0)) begin
            fails++;
            $display("FAIL a4_half: got %0d want %0d", n, hp(5, 0));
        end
    endtask

    task automatic test_octave();
        int n;
        repeat (200) cyc();
        octave = 2'd1;
        wait_change(hp(5, 0) + 10, n);
        tests++;
        if (n !== hp(5, 0) - 200) begin
            fails++;
            $display("FAIL oct_finish: got %0d want %0d", n, hp(5, 0) - 200);
        end
        for (int i = 0; i < 2; i++) begin
            wait_change(hp(5, 0) + 10, n);
            tests++;
            if (n !== hp(5, 1)) begin
                fails++;
                $display("FAIL oct_half: got %0d want %0d", n, hp(5, 1));
            end
        end
        octave = 2'd0;
    endtask

    task automatic test_release();
        int n;
        int k;
        rst = 1; keys = 0; cyc();
        rst = 0; keys = 8'b0000_0100;
        wait_change(10, n);
        repeat (400) cyc();
        keys = 0;
        wait_change(hp(2, 0) + 10, n);
        tests++;
        if (n !== hp(2, 0) - 400 || speaker !== 1'b0) begin
            fails++;
            $display("FAIL rel_hold: got %0d/%b want %0d/0",
                     n, speaker, hp(2, 0) - 400);
        end
`ifdef PIANO_SUSTAIN_EN
        k = 0;
        while (active === 1'b1 && k < int'(SUS) + 4 * hp(2, 0)) begin
            cyc();
            k++;
        end
        tests++;
        if (active !== 1'b0 || n + k < int'(SUS) || speaker !== 1'b0) begin
            fails++;
            $display("FAIL sustain_tail: got %0d cyc act %b spk %b want >=%0d",
                     n + k, active, speaker, SUS);
        end
`else
        tests++;
        if (active !== 1'b0 || note_idx !== 3'd0) begin
            fails++;
            $display("FAIL rel_idle: got %b/%0d want 0/0", active, note_idx);
        end
        k = 0;
        repeat (50) begin
            cyc();
            if (speaker !== 1'b0) k++;
        end
        tests++;
        if (k !== 0) begin
            fails++;
            $display("FAIL rel_silent: got %0d high cycles want 0", k);
        end
`endif
    endtask

    task automatic test_rst_mid();
        int n;
        rst = 1; keys = 0; cyc();
        rst = 0; keys = 8'b0010_0000;
        wait_change(10, n);
        repeat (100) cyc();
        rst = 1;
        cyc();
        tests++;
        if ({speaker, active, note_idx} !== 5'd0) begin
            fails++;
            $display("FAIL rst_mid: got %b%b%0d want 000",
                     speaker, active, note_idx);
        end
        rst = 0;
        wait_change(10, n);
        tests++;
        if (n !== 2 || note_idx !== 3'd5) begin
            fails++;
            $display("FAIL rst_restart: got %0d/%0d want 2/5", n, note_idx);
        end
        wait_change(hp(5, 0) + 10, n);
        tests++;
        if (n !== hp(5, 0)) begin
            fails++;
            $display("FAIL rst_half: got %0d want %0d", n, hp(5, 0));
        end
    endtask

    task automatic test_random();
        int r;
        int hold;
        rst = 1; keys = 0; cyc();
        rst = 0;
        for (int s = 0; s < 25; s++) begin
            r = $urandom_range(0, 11);
            rst = (r == 0);
            if (r < 4)
                keys = 8'd0;
            else if (r < 8)
                keys = 8'd1 << $urandom_range(0, 7);
            else
                keys = 8'($urandom);
            octave = 2'($urandom);
            hold = rst ? $urandom_range(1, 3) : $urandom_range(1, 2000);
            repeat (hold) begin
                cyc();
                tests++;
                if ({speaker, active, note_idx} !==
                    {m_spk, m_mode != 0, m_note}) begin
                    fails++;
                    $display("FAIL random: got %b%b%0d want %b%b%0d",
                             speaker, active, note_idx,
                             m_spk, m_mode != 0, m_note);
                end
            end
        end
        rst = 0; keys = 0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_priority();
        test_octave();
        test_release();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piano_tone_gen.md
PIANO_TONE_GEN -- requirements
Module: piano_tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, the clk frequency in Hz used to build the half-period table.
REQ-002 SHALL have parameter NUM_KEYS, default 8, the number of key inputs (range 1..8).
REQ-003 SHALL have parameter SUSTAIN_CYC, default 25000000, the release tail length in clk cycles (used only under PIANO_SUSTAIN_EN).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port keys  input  NUM_KEYS  key pressed = 1; bit 0 = C4 ... bit 7 = C5.
REQ-007 SHALL have port octave  input  2  octave shift 0..3; half-period divided by 2^octave.
REQ-008 SHALL have port speaker  output  1  square-wave tone.
REQ-009 SHALL have port active  output  1  high while state is PLAY or RELEASE.
REQ-010 SHALL have port note_idx  output  3  index of the note currently sounding; 0 when IDLE.

Function
REQ-011 SHALL register keys and octave once (1-cycle latency) before any use.
REQ-012 SHALL select the lowest-index pressed key when several are pressed (fixed priority).
REQ-013 SHALL use base half-period HP[i] = round(CLK_HZ/(2*f_i)) for f = 261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25 Hz; for the defaults E4 = 75843 and A4 = 56818.
REQ-014 SHALL use effective half-period N = HP[i] >> octave, and toggle speaker when the 17-bit counter reaches N-1, then clear the counter.
REQ-015 SHALL implement states IDLE, PLAY, RELEASE.
REQ-016 In IDLE, a registered key press SHALL load N, clear the counter, set speaker to 1 on the next cycle and enter PLAY.
REQ-017 In PLAY, a change of selected key or octave SHALL take effect only at the next toggle boundary; half-periods are never truncated.
REQ-018 In PLAY with all keys released, the block SHALL enter RELEASE.
REQ-019 In RELEASE, a new press SHALL return to PLAY with the new note applied at the next toggle boundary.
REQ-020 Without sustain, RELEASE SHALL finish the current half-period, then force speaker 0 and enter IDLE.
REQ-021 The counter SHALL never exceed N-1; if N shrinks mid-half-period the toggle SHALL occur at the first cycle with counter >= N-1.

Reset
REQ-022 rst SHALL be sampled only on clk rising edges and SHALL override all other inputs.
REQ-023 On reset: state IDLE, counter 0, sustain timer 0, speaker 0, active 0, note_idx 0, registered keys and octave 0.
REQ-024 Reset asserted mid-tone SHALL silence speaker on the next edge with no partial half-period.

Configuration
REQ-025 With macro PIANO_SUSTAIN_EN defined, RELEASE SHALL keep toggling the last note for SUSTAIN_CYC cycles after release, then stop at the next toggle boundary with speaker 0, and go IDLE.
REQ-026 Without PIANO_SUSTAIN_EN, there SHALL be no sustain timer, SUSTAIN_CYC SHALL be ignored, and REQ-020 applies.

Structure
REQ-027 Package piano_pkg SHALL hold the note frequency list, the HP table function of CLK_HZ, the counter width constant (17), and the state enum.
REQ-028 Sub-module piano_key_prio (combinational priority encoder: keys -> valid, index) SHALL be instantiated once.

Verification
REQ-029 rst 1 for 3 cycles, keys=0 -> speaker 0, active 0, note_idx 0 throughout.
REQ-030 keys=8'b0000_0100, octave 0 -> speaker rises 2 cycles after the press, toggles every 75843 cycles, note_idx 2.
REQ-031 keys=8'b0010_0100 -> E4 wins (note_idx 2); then keys=8'b0010_0000 -> A4 (56818-cycle half-periods) starts exactly at the next E4 toggle boundary.
REQ-032 A4 held, octave switched 0->1 mid-half-period -> current half-period completes at 56818 cycles, subsequent half-periods are 28409 cycles.
REQ-033 E4 released mid-half-period, no macro -> speaker holds its level to the boundary, then 0, active 0; with macro and SUSTAIN_CYC=500000 -> toggling continues for >=500000 cycles, then speaker 0.
REQ-034 rst pulsed during A4 playback -> speaker 0 and state IDLE on the next edge; tone restarts cleanly 2 cycles after rst drops.
